// File: rtl/bus_pkg.sv
// Shared types for the 8088 minimum-mode bus-cycle controller and the
// memory/I/O models that reuse its address decoder.
package bus_pkg;

  // Decoded target of a bus cycle; the first four values index cs bits.
  typedef enum logic [2:0] {
    MEM0 = 3'd0,
    MEM1 = 3'd1,
    IO0  = 3'd2,
    IO1  = 3'd3,
    MISS = 3'd4
  } region_e;

  // Bus-cycle sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WAIT  = 3'd2,
    XFER  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // Wait-state count, 0..7.
  typedef logic [2:0] ws_t;

  // Width of the one-hot chip-select vector.
  localparam int CS_W = 4;

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Local-bus signal bundle: processor-side pins plus the decoded device
// controls. The master is the processor/bench, the slave is the controller.
interface bus_cycle_ctrl_if;
  import bus_pkg::*;

  logic            ALE;
  logic            RD;
  logic            WR;
  logic            IOM;
  logic [11:0]     A;
  logic [7:0]      AD;
  logic            READY;
  logic [19:0]     addr;
  logic [CS_W-1:0] cs;
  logic            oe;
  logic            we;
  logic            err;

  modport master (
    output ALE, RD, WR, IOM, A, AD,
    input  READY, addr, cs, oe, we, err
  );

  modport slave (
    input  ALE, RD, WR, IOM, A, AD,
    output READY, addr, cs, oe, we, err
  );

endinterface

// File: rtl/bus_addr_decode.sv
// Combinational region decoder: maps a latched 20-bit address and the
// IO/M qualifier onto one of the four regions, or MISS.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter logic [11:0] IO0_BASE = 12'h000,
  parameter logic [11:0] IO1_BASE = 12'h001
) (
  input  logic [19:0] i_addr,
  input  logic        i_iom,
  output region_e     o_region
);

  // Memory splits on A19; I/O ports match on the 16-byte block addr[15:4].
  // IO0 wins if both bases are configured equal.
  always_comb begin
    o_region = MISS;
    if (!i_iom) begin
      o_region = i_addr[19] ? MEM1 : MEM0;
    end else if (i_addr[15:4] == IO0_BASE) begin
      o_region = IO0;
    end else if (i_addr[15:4] == IO1_BASE) begin
      o_region = IO1;
    end
  end

  // Address bits that play no part in region selection.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_addr[18:16], i_addr[3:0]};

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus-cycle controller: latches the multiplexed address on ALE, decodes the
// target region, drives one-hot cs with oe/we, and stretches the cycle with
// per-region wait states by holding READY low.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter ws_t         MEM0_WS  = 3'd0,
  parameter ws_t         MEM1_WS  = 3'd2,
  parameter ws_t         IO0_WS   = 3'd1,
  parameter ws_t         IO1_WS   = 3'd3,
  parameter logic [11:0] IO0_BASE = 12'h000,
  parameter logic [11:0] IO1_BASE = 12'h001
) (
  input logic             CLK,
  input logic             RESET,
  bus_cycle_ctrl_if.slave bus
);

  state_e          r_state;
  state_e          w_state_next;
  logic [19:0]     r_addr;
  logic [19:0]     w_addr_next;
  logic            r_iom;
  logic            w_iom_next;
  logic [CS_W-1:0] r_cs;
  logic [CS_W-1:0] w_cs_next;
  logic            r_oe;
  logic            w_oe_next;
  logic            r_we;
  logic            w_we_next;
  logic            r_ready;
  logic            w_ready_next;
  logic            r_err;
  logic            w_err_next;
  ws_t             r_wcnt;
  ws_t             w_wcnt_next;

  region_e         w_region;
  ws_t             w_ws;
  logic [CS_W-1:0] w_region_cs;
  logic            w_rd_low;
  logic            w_wr_low;
  logic            w_strobes_high;

  assign w_rd_low       = ~bus.RD;
  assign w_wr_low       = ~bus.WR;
  assign w_strobes_high = bus.RD & bus.WR;

  // Region comes from the latched address, so it is stable throughout ADDR.
  bus_addr_decode #(
    .IO0_BASE (IO0_BASE),
    .IO1_BASE (IO1_BASE)
  ) u_decode (
    .i_addr   (r_addr),
    .i_iom    (r_iom),
    .o_region (w_region)
  );

  // One-hot select per region; MISS matches no bit and yields all zeros.
  genvar gi;
  generate
    for (gi = 0; gi < CS_W; gi++) begin : g_cs
      assign w_region_cs[gi] = (w_region == region_e'(3'(gi)));
    end
  endgenerate

  // Wait-state count for the decoded region.
  always_comb begin
    w_ws = 3'd0;
    case (w_region)
      MEM0:    w_ws = MEM0_WS;
      MEM1:    w_ws = MEM1_WS;
      IO0:     w_ws = IO0_WS;
      IO1:     w_ws = IO1_WS;
      default: w_ws = 3'd0;
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_iom_next   = r_iom;
    w_cs_next    = r_cs;
    w_oe_next    = r_oe;
    w_we_next    = r_we;
    w_ready_next = r_ready;
    w_err_next   = 1'b0;
    w_wcnt_next  = r_wcnt;

    case (r_state)
      IDLE: begin
        // A strobe without a preceding ALE is not a cycle: ignore it.
        if (bus.ALE) begin
          w_addr_next  = {bus.A, bus.AD};
          w_iom_next   = bus.IOM;
          w_state_next = ADDR;
        end
      end

      ADDR: begin
        if (bus.ALE) begin
          w_addr_next = {bus.A, bus.AD};
          w_iom_next  = bus.IOM;
        end else if (w_rd_low && w_wr_low) begin
          w_err_next   = 1'b1;
          w_state_next = DRAIN;
        end else if (w_rd_low || w_wr_low) begin
          if (w_region == MISS) begin
            w_err_next   = 1'b1;
            w_state_next = DRAIN;
          end else begin
            // Direction is captured here and held for the rest of the cycle.
            w_cs_next   = w_region_cs;
            w_oe_next   = w_rd_low;
            w_we_next   = w_wr_low;
            w_wcnt_next = w_ws;
            if (w_ws != 3'd0) begin
              w_ready_next = 1'b0;
              w_state_next = WAIT;
            end else begin
              w_state_next = XFER;
            end
          end
        end
      end

      WAIT: begin
        if (bus.ALE) begin
          w_err_next   = 1'b1;
          w_cs_next    = '0;
          w_oe_next    = 1'b0;
          w_we_next    = 1'b0;
          w_ready_next = 1'b1;
          w_wcnt_next  = 3'd0;
          w_addr_next  = {bus.A, bus.AD};
          w_iom_next   = bus.IOM;
          w_state_next = ADDR;
        end else begin
          // READY rises on the edge where the count reaches zero, giving
          // exactly WS low cycles counted from the cs assertion.
          w_wcnt_next = r_wcnt - 3'd1;
          if (r_wcnt == 3'd1) begin
            w_ready_next = 1'b1;
            w_state_next = XFER;
          end
        end
      end

      XFER: begin
        if (bus.ALE) begin
          w_err_next   = 1'b1;
          w_cs_next    = '0;
          w_oe_next    = 1'b0;
          w_we_next    = 1'b0;
          w_ready_next = 1'b1;
          w_wcnt_next  = 3'd0;
          w_addr_next  = {bus.A, bus.AD};
          w_iom_next   = bus.IOM;
          w_state_next = ADDR;
        end else if (w_strobes_high) begin
          w_cs_next    = '0;
          w_oe_next    = 1'b0;
          w_we_next    = 1'b0;
          w_state_next = IDLE;
        end
      end

      DRAIN: begin
        if (w_strobes_high) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_iom   <= 1'b0;
      r_cs    <= '0;
      r_oe    <= 1'b0;
      r_we    <= 1'b0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
      r_wcnt  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_iom   <= w_iom_next;
      r_cs    <= w_cs_next;
      r_oe    <= w_oe_next;
      r_we    <= w_we_next;
      r_ready <= w_ready_next;
      r_err   <= w_err_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  assign bus.READY = r_ready;
  assign bus.addr  = r_addr;
  assign bus.cs    = r_cs;
  assign bus.oe    = r_oe;
  assign bus.we    = r_we;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: stimulus pushes expected cycle and
// error records; a negedge monitor builds records from the DUT outputs and
// compares them against the queue.
module tb_bus_cycle_ctrl;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_cycle_ctrl_if bus_if ();

  bus_cycle_ctrl #(
    .MEM0_WS  (3'd0),
    .MEM1_WS  (3'd2),
    .IO0_WS   (3'd1),
    .IO1_WS   (3'd3),
    .IO0_BASE (12'h000),
    .IO1_BASE (12'h001)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_if)
  );

  // One observed bus event: a chip-select window or an err pulse.
  typedef struct packed {
    logic        is_err;
    logic [19:0] addr;
    logic [3:0]  cs;
    logic        oe;
    logic        we;
    logic [7:0]  rl;   // cycles with READY low while cs was asserted
    logic [7:0]  len;  // cycles cs was asserted
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stray  = 0;
  logic mon_en = 1'b0;
  logic in_cyc = 1'b0;
  rec_t cur;
  rec_t mon_e;

  task automatic push_x(input logic [19:0] a, input logic [3:0] c, input logic oe,
                        input logic we, input int rl, input int len);
    rec_t r;
    r = '0;
    r.addr = a; r.cs = c; r.oe = oe; r.we = we;
    r.rl = 8'(rl); r.len = 8'(len);
    exp_q.push_back(r);
  endtask

  task automatic push_e(input logic [19:0] a);
    rec_t r;
    r = '0;
    r.is_err = 1'b1;
    r.addr = a;
    exp_q.push_back(r);
  endtask

  task automatic score(input rec_t got);
    rec_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got err=%0b addr=%05h cs=%b oe=%0b we=%0b rl=%0d len=%0d, queue empty",
               got.is_err, got.addr, got.cs, got.oe, got.we, got.rl, got.len);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL bus_event: got err=%0b addr=%05h cs=%b oe=%0b we=%0b rl=%0d len=%0d, want err=%0b addr=%05h cs=%b oe=%0b we=%0b rl=%0d len=%0d",
                 got.is_err, got.addr, got.cs, got.oe, got.we, got.rl, got.len,
                 e.is_err, e.addr, e.cs, e.oe, e.we, e.rl, e.len);
      end else begin
        $display("event ok: err=%0b addr=%05h cs=%b oe=%0b we=%0b rl=%0d len=%0d",
                 got.is_err, got.addr, got.cs, got.oe, got.we, got.rl, got.len);
      end
    end
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %05h, want %05h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_cyc) begin
        if (bus_if.cs == 4'b0000) begin
          in_cyc = 1'b0;
          score(cur);
        end else begin
          cur.len = cur.len + 8'd1;
          if (!bus_if.READY) cur.rl = cur.rl + 8'd1;
        end
      end else if (bus_if.cs != 4'b0000) begin
        in_cyc   = 1'b1;
        cur      = '0;
        cur.addr = bus_if.addr;
        cur.cs   = bus_if.cs;
        cur.oe   = bus_if.oe;
        cur.we   = bus_if.we;
        cur.len  = 8'd1;
        cur.rl   = bus_if.READY ? 8'd0 : 8'd1;
      end
      if (bus_if.err) begin
        mon_e        = '0;
        mon_e.is_err = 1'b1;
        mon_e.addr   = bus_if.addr;
        mon_e.cs     = bus_if.cs;
        mon_e.oe     = bus_if.oe;
        mon_e.we     = bus_if.we;
        score(mon_e);
      end
      if (!bus_if.READY && bus_if.cs == 4'b0000) stray++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ALE for one cycle, then the chosen strobe(s) low for n edges, then idle.
  task automatic bus_cycle(input logic [19:0] a, input logic iom, input logic rd,
                           input logic wr, input int n);
    bus_if.ALE = 1'b1;
    bus_if.A   = a[19:8];
    bus_if.AD  = a[7:0];
    bus_if.IOM = iom;
    tick();
    bus_if.ALE = 1'b0;
    bus_if.RD  = ~rd;
    bus_if.WR  = ~wr;
    repeat (n) tick();
    bus_if.RD = 1'b1;
    bus_if.WR = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.ALE = 1'b0;
    bus_if.RD  = 1'b1;
    bus_if.WR  = 1'b1;
    bus_if.IOM = 1'b0;
    bus_if.A   = 12'h000;
    bus_if.AD  = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    check("reset_ready", 20'(bus_if.READY), 20'h1);
    check("reset_addr",  bus_if.addr,       20'h0);
    check("reset_cs",    20'(bus_if.cs),    20'h0);
    check("reset_oe",    20'(bus_if.oe),    20'h0);
    check("reset_we",    20'(bus_if.we),    20'h0);
    check("reset_err",   20'(bus_if.err),   20'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // MEM0 read, no wait states, RD low 4 cycles.
    push_x(20'h01234, 4'b0001, 1'b1, 1'b0, 0, 4);
    bus_cycle(20'h01234, 1'b0, 1'b1, 1'b0, 4);
    check("mem0_addr_held", bus_if.addr, 20'h01234);

    // MEM1 write, 2 wait states.
    push_x(20'h80010, 4'b0010, 1'b0, 1'b1, 2, 4);
    bus_cycle(20'h80010, 1'b0, 1'b0, 1'b1, 4);

    // IO1 read at port 0015, 3 wait states.
    push_x(20'h00015, 4'b1000, 1'b1, 1'b0, 3, 5);
    bus_cycle(20'h00015, 1'b1, 1'b1, 1'b0, 5);

    // IO read at port 0200: decode miss.
    push_e(20'h00200);
    bus_cycle(20'h00200, 1'b1, 1'b1, 1'b0, 3);

    // IO0 write at port 0003, 1 wait state.
    push_x(20'h00003, 4'b0100, 1'b0, 1'b1, 1, 3);
    bus_cycle(20'h00003, 1'b1, 1'b0, 1'b1, 3);

    // RD and WR low together.
    push_e(20'h00500);
    bus_cycle(20'h00500, 1'b0, 1'b1, 1'b1, 2);

    // Strobe in IDLE with no ALE: nothing may happen.
    bus_if.RD = 1'b0;
    repeat (3) tick();
    bus_if.RD = 1'b1;
    tick();

    // RESET during WAIT of a MEM1 write.
    push_x(20'h8ABCD, 4'b0010, 1'b0, 1'b1, 2, 2);
    bus_if.ALE = 1'b1;
    bus_if.A   = 12'h8AB;
    bus_if.AD  = 8'hCD;
    bus_if.IOM = 1'b0;
    tick();
    bus_if.ALE = 1'b0;
    bus_if.WR  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_wait_ready", 20'(bus_if.READY), 20'h1);
    check("rst_wait_cs",    20'(bus_if.cs),    20'h0);
    check("rst_wait_we",    20'(bus_if.we),    20'h0);
    check("rst_wait_addr",  bus_if.addr,       20'h0);
    rst = 1'b0;
    bus_if.WR = 1'b1;
    tick();
    push_x(20'h80004, 4'b0010, 1'b1, 1'b0, 2, 3);
    bus_cycle(20'h80004, 1'b0, 1'b1, 1'b0, 3);

    // ALE during XFER of an IO0 read aborts it; next RD goes to the new region.
    push_x(20'h00007, 4'b0100, 1'b1, 1'b0, 1, 3);
    push_e(20'h80020);
    push_x(20'h80020, 4'b0010, 1'b1, 1'b0, 2, 4);
    bus_if.ALE = 1'b1;
    bus_if.A   = 12'h000;
    bus_if.AD  = 8'h07;
    bus_if.IOM = 1'b1;
    tick();
    bus_if.ALE = 1'b0;
    bus_if.RD  = 1'b0;
    repeat (3) tick();
    bus_if.RD  = 1'b1;
    bus_if.ALE = 1'b1;
    bus_if.A   = 12'h800;
    bus_if.AD  = 8'h20;
    bus_if.IOM = 1'b0;
    tick();
    check("abort_addr", bus_if.addr, 20'h80020);
    bus_if.ALE = 1'b0;
    bus_if.RD  = 1'b0;
    repeat (4) tick();
    bus_if.RD = 1'b1;
    repeat (4) tick();

    check("queue_drained", 20'(exp_q.size()), 20'h0);
    check("ready_low_without_cs", 20'(stray), 20'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
